// File: rtl/bi_mem_tp_sync.sv
// Single-clock two-port memory: one read port, one lane-masked write port, read pipeline of READ_LATENCY stages.
// Optional post-reset clear sweep enabled by defining BI_MEM_TP_CLEAR_EN.
module bi_mem_tp_sync #(
  parameter int    WIDTH        = 16,
  parameter int    HEIGHT       = 16,
  parameter int    LANE         = 8,
  parameter int    READ_LATENCY = 1,
  parameter string COLLISION    = "WRITE_FIRST"
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      readEnable_i,
  input  logic [$clog2(HEIGHT)-1:0] readAddr_i,
  output logic [WIDTH-1:0]          readData_o,
  output logic                      readValid_o,
  input  logic                      writeEnable_i,
  input  logic [$clog2(HEIGHT)-1:0] writeAddr_i,
  input  logic [WIDTH/LANE-1:0]     writeMask_i,
  input  logic [WIDTH-1:0]          writeData_i,
  output logic                      busy_o
);

  localparam int             AW       = $clog2(HEIGHT);
  localparam int             LANES    = WIDTH / LANE;
  localparam int             PIPE     = (READ_LATENCY < 1) ? 1 : (READ_LATENCY > 4) ? 4 : READ_LATENCY;
  localparam bit             WR_FIRST = (COLLISION == "WRITE_FIRST");
  localparam logic [AW:0]    DEPTH    = (AW+1)'(HEIGHT);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    PanicModule #(.MSG("READ_LATENCY must be in 1..4")) u_panic ();
  end
  if (WIDTH % LANE != 0) begin : g_bad_lane
    PanicModule #(.MSG("WIDTH must be a multiple of LANE")) u_panic ();
  end
  if (COLLISION != "WRITE_FIRST" && COLLISION != "READ_FIRST") begin : g_bad_collision
    PanicModule #(.MSG("COLLISION must be WRITE_FIRST or READ_FIRST")) u_panic ();
  end
  if (HEIGHT < 2) begin : g_bad_height
    PanicModule #(.MSG("HEIGHT must be at least 2")) u_panic ();
  end

  logic [WIDTH-1:0] mem [HEIGHT];

  logic             busy;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             user_wr;
  logic             rd_accept;
  logic             rd_in_range;
  logic [WIDTH-1:0] rd_word;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [LANES-1:0] mem_wmask;
  logic [WIDTH-1:0] mem_wdata;

  // Addresses at or above HEIGHT only exist when HEIGHT is not a power of two.
  assign user_wr     = writeEnable_i && !rst_i && !busy && ({1'b0, writeAddr_i} < DEPTH);
  assign rd_accept   = readEnable_i && !rst_i && !busy;
  assign rd_in_range = ({1'b0, readAddr_i} < DEPTH);

`ifdef BI_MEM_TP_CLEAR_EN
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} clr_state_t;
  localparam logic [AW-1:0] LAST_ADDR = AW'(HEIGHT - 1);

  clr_state_t    state, state_next;
  logic [AW-1:0] clr_cnt, clr_cnt_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // The first post-reset edge already writes address 0, so the sweep spans exactly HEIGHT cycles.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    sweep_we     = 1'b0;
    case (state)
      ST_RESET, ST_CLEAR: begin
        sweep_we = !rst_i;
        if (clr_cnt == LAST_ADDR) begin
          state_next = ST_READY;
        end else begin
          state_next   = ST_CLEAR;
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      ST_READY: ;
      default:  state_next = ST_RESET;
    endcase
  end

  assign sweep_addr = clr_cnt;
  assign busy       = (state != ST_READY);
`else
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
  assign busy       = 1'b0;
`endif

  assign busy_o = busy;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it holding and a latch is never inferred.
  always_comb begin
    mem_we    = user_wr;
    mem_waddr = writeAddr_i;
    mem_wmask = writeMask_i;
    mem_wdata = writeData_i;
    if (sweep_we) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
      mem_wmask = '1;
      mem_wdata = '0;
    end
  end

  // NOTE: the storage array has no reset branch; resetting it would turn a RAM into a register file.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wmask[i]) mem[mem_waddr][i*LANE +: LANE] <= mem_wdata[i*LANE +: LANE];
      end
    end
  end

  // Write-first merges the incoming masked lanes over the old word on a same-address collision.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[readAddr_i];
      if (WR_FIRST && user_wr && (writeAddr_i == readAddr_i)) begin
        for (int i = 0; i < LANES; i++) begin
          if (writeMask_i[i]) rd_word[i*LANE +: LANE] = writeData_i[i*LANE +: LANE];
        end
      end
    end
  end

  logic [WIDTH-1:0] pipe_data [PIPE];
  logic [PIPE-1:0]  pipe_valid;

  // NOTE: clocked state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      for (int i = 0; i < PIPE; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      if (rd_accept) pipe_data[0] <= rd_word;
      for (int i = 1; i < PIPE; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign readData_o  = pipe_data[PIPE-1];
  assign readValid_o = pipe_valid[PIPE-1];

endmodule

// Elaboration-time guard: only instantiated for an illegal parameter set, where it stops elaboration with MSG.
module PanicModule #(
  parameter string MSG = ""
) ();
  if (MSG != "") begin : g_fire
    $fatal(1, "bi_mem_tp_sync: %s", MSG);
  end
endmodule

// File: doc/bi_mem_tp_sync.md
Name: bi_mem_tp_sync

Overview:
Single-clock two-port memory (one read port, one write port) for the bilib memory family, in a behavioural, synthesisable form.
- Next generation of the two-port memory interface: adds lane write masks, a configurable read pipeline with a valid strobe, and defined read/write collision semantics.
- Optional post-reset clear sweep.
- Used as the storage primitive under FIFOs and buffers wherever read and write share one clock.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of LANE
HEIGHT, 16, number of words; need not be a power of two
LANE, 8, bits per write-mask lane
READ_LATENCY, 1, cycles from read request to data; legal range 1..4
COLLISION, "WRITE_FIRST", same-address read/write policy: "WRITE_FIRST" or "READ_FIRST"

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
readEnable_i  in  1  read request this cycle
readAddr_i  in  $clog2(HEIGHT)  read address
readData_o  out  WIDTH  read data
readValid_o  out  1  readData_o is valid this cycle
writeEnable_i  in  1  write request this cycle
writeAddr_i  in  $clog2(HEIGHT)  write address
writeMask_i  in  WIDTH/LANE  per-lane write enable; bit i covers bits [i*LANE +: LANE]
writeData_i  in  WIDTH  write data
busy_o  out  1  memory unavailable (clear sweep running)

Behaviour:
- Reset (rst_i high at an edge):
  - readValid_o=0, readData_o=0, all read pipeline stages invalidated.
  - busy_o=0 without the optional feature.
  - Array contents are not modified by reset.
- Any read or write presented in the same cycle as rst_i is ignored.
- Reads:
  - A read accepted at edge t (readEnable_i=1) produces readData_o and readValid_o=1 exactly READ_LATENCY edges later (visible after edge t+READ_LATENCY-1 when READ_LATENCY=1 means registered output).
  - Back-to-back reads are fully pipelined, one result per cycle, in order.
  - readValid_o is high for one cycle per accepted read.
  - readData_o holds its last value while readValid_o=0.
- Writes:
  - Lane i of the word at writeAddr_i is updated when writeEnable_i=1 and writeMask_i[i]=1.
  - Mask all zeros: no change.
  - New contents are visible to any read accepted on a later edge.
- Collision (same-edge read and write to the same address):
  - WRITE_FIRST: the read returns masked-lane new data merged with old data in the unmasked lanes.
  - READ_FIRST: the read returns the pre-write word.
  - The write always completes.
- Out-of-range address (>= HEIGHT, non-power-of-two HEIGHT only):
  - Write is dropped.
  - Read returns 0 with readValid_o=1 at the normal latency.
- Reset mid-operation: in-flight reads are discarded and produce no valid. After reset deasserts, the first valid can appear no earlier than READ_LATENCY cycles after the first post-reset read.
- Illegal parameters instantiate PanicModule with a descriptive message:
  - READ_LATENCY outside 1..4
  - WIDTH % LANE != 0
  - unknown COLLISION string
  - HEIGHT < 2

Optional Feature:
Macro BI_MEM_TP_CLEAR_EN.
- Enabled: a clear FSM with states RESET, CLEAR, READY.
  - rst_i forces RESET.
  - First edge with rst_i low enters CLEAR: counter 0..HEIGHT-1 writes all-zero words, one address per cycle.
  - Reaching HEIGHT-1 moves to READY.
  - busy_o=1 in RESET and CLEAR, 0 in READY. The clear therefore takes HEIGHT cycles after reset release.
  - While busy_o=1: user writes are dropped, user reads are dropped and produce no readValid_o.
  - rst_i asserted during CLEAR restarts the sweep from address 0 after release.
- Disabled: no FSM; busy_o is constant 0; array contents after power-up are undefined (X in simulation).

Test Plan:
- Latency sweep: READ_LATENCY=1..4 each; write 0xA5A5 @3, read @3 next cycle -> readData_o=0xA5A5 with readValid_o=1 exactly READ_LATENCY edges after the read request, single-cycle strobe.
- Lane mask: WIDTH=16; write 0x1234 @5 mask=11, then write 0xFFFF @5 mask=01, read @5 -> 0x12FF.
- Collision: @7 holds 0x0000; same edge write 0xBEEF mask=11 and read @7 -> WRITE_FIRST returns 0xBEEF; READ_FIRST returns 0x0000; a following read returns 0xBEEF in both.
- Streaming: READ_LATENCY=3; reads @0..15 back-to-back after writing addr*3 -> 16 consecutive valids, data 0,3,6,...,45 in order, no gaps.
- Reset mid-flight: READ_LATENCY=4; issue 3 reads, assert rst_i at the 2nd edge -> no readValid_o afterwards, readData_o=0; HEIGHT=12, read @13 -> data 0 with valid.
- Clear (BI_MEM_TP_CLEAR_EN, HEIGHT=16):
  - Prefill 0xFFFF, pulse rst_i -> busy_o high 16 cycles; a read during busy yields no valid; afterwards every address reads 0x0000.
  - Re-asserting rst_i at clear cycle 8 -> busy_o lasts 16 more cycles after release.
